// File: rtl/meter_pkg.sv
// Shared constants and types for the parking-meter display controller.
//   TIME_W/SUM_W/BCD_W : datapath widths
//   MODE_*             : display mode encodings
//   ADD_* / SET_*      : button increments and load values
//   bcd4_t             : four packed BCD digits, d3 = thousands
package meter_pkg;

  localparam int unsigned TIME_W         = 14;
  localparam int unsigned SUM_W          = 15;
  localparam int unsigned BCD_W          = 16;
  localparam int unsigned MAX_TIME_DEF   = 9999;
  localparam int unsigned LOW_THRESH_DEF = 180;

  localparam logic [1:0] MODE_EXPIRED = 2'd0;
  localparam logic [1:0] MODE_LOW     = 2'd1;
  localparam logic [1:0] MODE_NORMAL  = 2'd2;

  localparam logic [TIME_W-1:0] ADD_10  = 14'd10;
  localparam logic [TIME_W-1:0] ADD_180 = 14'd180;
  localparam logic [TIME_W-1:0] ADD_200 = 14'd200;
  localparam logic [TIME_W-1:0] ADD_550 = 14'd550;
  localparam logic [TIME_W-1:0] SET_10  = 14'd10;
  localparam logic [TIME_W-1:0] SET_205 = 14'd205;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd4_t;

  // Display mode derived from the remaining time.
  function automatic logic [1:0] mode_of(input logic [TIME_W-1:0] t,
                                         input logic [TIME_W-1:0] thresh);
    if (t == '0)         return MODE_EXPIRED;
    else if (t < thresh) return MODE_LOW;
    else                 return MODE_NORMAL;
  endfunction

endpackage

// File: rtl/bin2bcd14.sv
// Combinational 14-bit binary to 4-digit BCD converter (double dabble).
//   bin_i : binary value, expected range 0..9999
//   bcd_o : four BCD digits
module bin2bcd14
  import meter_pkg::*;
(
  input  logic [TIME_W-1:0] bin_i,
  output bcd4_t             bcd_o
);

  localparam int unsigned SR_W = BCD_W + TIME_W;

  logic [SR_W-1:0] sr;

  // Shift-and-add-3: correct each digit >= 5 before every shift.
  always_comb begin
    sr = {BCD_W'(0), bin_i};
    for (int i = 0; i < TIME_W; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[TIME_W+4*d +: 4] >= 4'd5) begin
          sr[TIME_W+4*d +: 4] = sr[TIME_W+4*d +: 4] + 4'd3;
        end
      end
      sr = sr << 1;
    end
    bcd_o = sr[SR_W-1 -: BCD_W];
  end

endmodule

// File: rtl/meter_display_ctrl.sv
// Parking-meter display sequencer: holds remaining seconds, applies add/set
// buttons, counts down once per second and drives BCD digits plus a blink
// enable for the anode drivers.
//   clk, rst_n              : clock, async active-low reset
//   add_10..add_550         : single-cycle add pulses (accumulate if coincident)
//   set_10, set_205         : single-cycle load pulses (set_205 wins)
//   bcd0..bcd3              : registered BCD digits of the remaining time
//   disp_en                 : registered display enable (blink pattern)
//   mode                    : 0 expired, 1 low, 2 normal (from current time)
module meter_display_ctrl
  import meter_pkg::*;
#(
  parameter int unsigned HALF_DIV   = 50000000,
  parameter int unsigned LOW_THRESH = LOW_THRESH_DEF,
  parameter int unsigned MAX_TIME   = MAX_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       add_10,
  input  logic       add_180,
  input  logic       add_200,
  input  logic       add_550,
  input  logic       set_10,
  input  logic       set_205,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       disp_en,
  output logic [1:0] mode
);

  localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              half_q, half_d;
  logic              phase_q, phase_d;
  logic              par_q, par_d;
  logic [TIME_W-1:0] time_q, time_d;
  bcd4_t             bcd_q, bcd_c;
  logic              disp_en_q, disp_en_d;

  logic              sec_tick_c;
  logic              dec_c;
  logic [SUM_W-1:0]  add_sum_c;
  logic [SUM_W-1:0]  sum_c;
  logic [1:0]        mode_c;

  assign sec_tick_c = half_q & phase_q;
  assign dec_c      = sec_tick_c & (time_q != '0);
  assign mode_c     = mode_of(time_q, TIME_W'(LOW_THRESH));

  bin2bcd14 u_bin2bcd (
    .bin_i (time_q),
    .bcd_o (bcd_c)
  );

  // Next-state: prescaler, time update and blink enable.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    half_d    = 1'b0;
    phase_d   = phase_q ^ half_q;
    par_d     = par_q ^ sec_tick_c;
    add_sum_c = '0;
    sum_c     = '0;
    time_d    = time_q;
    disp_en_d = 1'b1;

    if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
      cnt_d  = '0;
      half_d = 1'b1;
    end

    if (add_10)  add_sum_c = add_sum_c + SUM_W'(ADD_10);
    if (add_180) add_sum_c = add_sum_c + SUM_W'(ADD_180);
    if (add_200) add_sum_c = add_sum_c + SUM_W'(ADD_200);
    if (add_550) add_sum_c = add_sum_c + SUM_W'(ADD_550);

    sum_c = SUM_W'(time_q) - SUM_W'(dec_c) + add_sum_c;

    // A load restarts the second so the new value shows for a full second.
    if (set_205 || set_10) begin
      time_d  = set_205 ? SET_205 : SET_10;
      cnt_d   = '0;
      half_d  = 1'b0;
      phase_d = 1'b0;
      par_d   = 1'b0;
    end else if (sum_c > SUM_W'(MAX_TIME)) begin
      time_d = TIME_W'(MAX_TIME);
    end else begin
      time_d = sum_c[TIME_W-1:0];
    end

    case (mode_c)
      MODE_NORMAL: disp_en_d = 1'b1;
      MODE_LOW:    disp_en_d = ~phase_q;
      default:     disp_en_d = ~par_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      half_q    <= 1'b0;
      phase_q   <= 1'b0;
      par_q     <= 1'b0;
      time_q    <= '0;
      bcd_q     <= '0;
      disp_en_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      par_q     <= par_d;
      time_q    <= time_d;
      bcd_q     <= bcd_c;
      disp_en_q <= disp_en_d;
    end
  end

  assign bcd0    = bcd_q.d0;
  assign bcd1    = bcd_q.d1;
  assign bcd2    = bcd_q.d2;
  assign bcd3    = bcd_q.d3;
  assign disp_en = disp_en_q;
  assign mode    = mode_c;

endmodule

// File: doc/meter_display_ctrl.md
Name: meter_display_ctrl

Overview:
- Sequencing controller for the 4-digit 7-segment display driver in the parking-meter design.
- Holds the remaining time in seconds and applies add-time and set-time button pulses.
- Counts the time down once per second and outputs the four BCD digits.
- Generates the display-enable blink pattern (normal / low-time / expired), which downstream gates the anodes.

Parameters:
HALF_DIV, 50000000, clk cycles per half-second strobe (100 MHz board); set small (e.g. 4) in simulation.
LOW_THRESH, 180, remaining-time value below which the display enters the LOW blink mode.
MAX_TIME, 9999, saturation ceiling in seconds (4 BCD digits).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
add_10  in  1  single-cycle pulse: add 10 s
add_180  in  1  single-cycle pulse: add 180 s
add_200  in  1  single-cycle pulse: add 200 s
add_550  in  1  single-cycle pulse: add 550 s
set_10  in  1  single-cycle pulse: load 10 s
set_205  in  1  single-cycle pulse: load 205 s
bcd0  out  4  ones digit (registered)
bcd1  out  4  tens digit (registered)
bcd2  out  4  hundreds digit (registered)
bcd3  out  4  thousands digit (registered)
disp_en  out  1  display enable, active high (registered)
mode  out  2  current mode: 0 EXPIRED, 1 LOW, 2 NORMAL

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). All state is cleared on rst_n low regardless of clk.
- Reset values:
  - time=0; bcd0..bcd3=0
  - prescaler=0; half_tick=0; phase=0; sec_par=0
  - mode=EXPIRED; disp_en=1
- Prescaler:
  - Counts 0..HALF_DIV-1.
  - half_tick is a one-cycle strobe when the count wraps.
  - phase toggles on each half_tick.
  - sec_tick = half_tick && phase==1, i.e. one strobe per second.
  - sec_par toggles on each sec_tick.
- Time update, per cycle, in priority order:
  1. set_205 → time=205; else set_10 → time=10. Prescaler, phase and sec_par reset to 0 in the same cycle, so a fresh second starts. Any add or decrement in that cycle is discarded.
  2. Otherwise: next = time − dec + add_sum.
     - dec = sec_tick && time>0.
     - add_sum = sum of all asserted add_* pulses (simultaneous pulses accumulate).
     - The result saturates at MAX_TIME.
     - Arithmetic is 14-bit unsigned with a 15-bit intermediate before saturation.
- time never wraps below 0: a decrement at 0 is suppressed.
- Mode, combinational from time:
  - time==0 → EXPIRED
  - 0<time<LOW_THRESH → LOW
  - else NORMAL
- disp_en, registered next cycle:
  - NORMAL: 1
  - LOW: ~phase (on for the first half of each second, off for the second)
  - EXPIRED: ~sec_par (1 s on, 1 s off)
- BCD outputs:
  - Registered from a combinational binary-to-BCD conversion of time.
  - Latency: 1 cycle after time updates.
  - disp_en shares that latency, so digits and blink stay aligned.
- Boundaries:
  - add at time=9995 with add_10 → 9999.
  - add pulse coinciding with sec_tick at time=0 → time=add_sum; no decrement.
  - Transition LOW→EXPIRED when time reaches 0: blink switches to the sec_par pattern on the next cycle.
  - Reset asserted mid-countdown → time=0 immediately (async); counting resumes only after rst_n deasserts and a set/add arrives.

Decomposition:
- Shared package meter_pkg holds:
  - mode encodings (MODE_EXPIRED=2'd0, MODE_LOW=2'd1, MODE_NORMAL=2'd2)
  - add constants (10, 180, 200, 550)
  - set constants (10, 205)
  - MAX_TIME and LOW_THRESH defaults
- One sub-module, bin2bcd14: combinational double-dabble, 14-bit binary in, four 4-bit BCD digits out.
- Prescaler, time register and blink logic stay in meter_display_ctrl.

Test Plan (HALF_DIV=4, so sec_tick every 8 clk):
- Reset release, no input → time 0; bcd=0000; mode=EXPIRED; disp_en 1 for 8 cycles, then 0 for 8, alternating.
- set_205 pulse → bcd=0205, mode=NORMAL, disp_en=1; after 26 sec_ticks bcd=0179, mode=LOW, and disp_en shows 4 cycles high / 4 cycles low.
- set_10, then let expire → bcd counts 0010…0000 one step per 8 clk; holds at 0000 with no further decrement; mode=EXPIRED.
- set_10, then add_180 and add_550 in the same cycle → bcd=0740. Add_550 pulsed 17 more times → bcd=9999 (saturated) and stays 9999 with further adds.
- From time=0, add_10 coincident with sec_tick → bcd=0010, not 0009. From time=100, set_10 coincident with add_200 → bcd=0010 and the prescaler restarts from 0.
- rst_n driven low asynchronously mid-count at bcd=0150 → outputs reach reset values (0000, disp_en=1, mode=0) without waiting for a clk edge.
